// File: rtl/ps2_host_tx_pkg.sv
// rtl/ps2_host_tx_pkg.sv - shared PS/2 host transmitter definitions
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_REL
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  localparam int DEF_INHIBIT_CYCLES = 6000;
  localparam int DEF_TIMEOUT_CYCLES = 750000;
  localparam int DEF_SYNC_STAGES    = 3;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake between a client and the PS/2 transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_ack_ok;
  logic       tx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, tx_ack_ok, tx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, tx_ack_ok, tx_err
  );
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// rtl/ps2_host_tx_line_sync.sv - PS/2 line synchroniser with a falling-edge strobe on the clock line
module ps2_host_tx_line_sync #(
  parameter int STAGES = 3
) (
  input  logic clk_50m,
  input  logic clr_n,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic sync_clk,
  output logic sync_data,
  output logic clk_fall
);
  logic [STAGES-1:0] clk_sr;
  logic [STAGES-1:0] data_sr;
  logic              clk_prev;

  // Idle bus is pulled high, so the chains reset to 1 to avoid a phantom fall.
  always_ff @(posedge clk_50m or negedge clr_n) begin
    if (!clr_n) begin
      clk_sr   <= '1;
      data_sr  <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= {clk_sr[STAGES-2:0], ps2_clk_in};
      data_sr  <= {data_sr[STAGES-2:0], ps2_data_in};
      clk_prev <= clk_sr[STAGES-1];
    end
  end

  assign sync_clk  = clk_sr[STAGES-1];
  assign sync_data = data_sr[STAGES-1];
  assign clk_fall  = clk_prev & ~sync_clk;
endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic         clk_50m,
  input  logic         clr_n,
  ps2_host_tx_if.slave tx,
  output logic         rx_inhibit,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state, state_n;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [3:0]       bitcnt;
  logic [TMR_W-1:0] tmr;
  logic             drive_q;
  logic             ack_ok_q;
  logic             sync_clk, sync_data, clk_fall;
  logic             accept, timeout, tmr_restart, done, err, clk_oe, data_oe;

  ps2_host_tx_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_50m    (clk_50m),
    .clr_n      (clr_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .sync_clk   (sync_clk),
    .sync_data  (sync_data),
    .clk_fall   (clk_fall)
  );

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    tmr_restart = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    clk_oe      = 1'b0;
    data_oe     = 1'b0;
    timeout     = (state == ST_REQ || state == ST_SEND || state == ST_ACK || state == ST_WAIT_REL)
                  && (tmr == TMO_LAST);
    case (state)
      ST_IDLE: if (tx.tx_valid) begin
        accept  = 1'b1;
        state_n = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        clk_oe = 1'b1;
        if (tmr == INH_LAST) begin
          data_oe     = 1'b1;
          tmr_restart = 1'b1;
          state_n     = ST_REQ;
        end
      end
      ST_REQ: begin
        data_oe = 1'b1;
        state_n = ST_SEND;
      end
      ST_SEND: begin
        data_oe = drive_q;
        if (clk_fall && bitcnt == 4'd9) state_n = ST_ACK;
      end
      ST_ACK: if (clk_fall) state_n = ST_WAIT_REL;
      ST_WAIT_REL: if (sync_clk && sync_data) begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    // An unresponsive device must never leave the bus held.
    if (timeout) begin
      state_n = ST_IDLE;
      clk_oe  = 1'b0;
      data_oe = 1'b0;
      done    = 1'b0;
      err     = 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_IDLE;
      data_q   <= '0;
      parity_q <= 1'b0;
      bitcnt   <= '0;
      tmr      <= '0;
      drive_q  <= 1'b0;
      ack_ok_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept || tmr_restart) tmr <= '0;
      else if (tmr != '1)        tmr <= tmr + 1'b1;
      if (accept) begin
        data_q   <= tx.tx_data;
        parity_q <= odd_parity(tx.tx_data);
        bitcnt   <= '0;
      end
      // bitcnt holds the falls already seen, so it indexes the bit presented on this fall.
      if (state == ST_REQ) begin
        drive_q <= 1'b1;
      end else if (state == ST_SEND && clk_fall) begin
        bitcnt <= bitcnt + 4'd1;
        if (bitcnt < 4'd8)       drive_q <= ~data_q[bitcnt[2:0]];
        else if (bitcnt == 4'd8) drive_q <= ~parity_q;
        else                     drive_q <= 1'b0;
      end
      if (accept || timeout)                 ack_ok_q <= 1'b0;
      else if (state == ST_ACK && clk_fall)  ack_ok_q <= ~sync_data;
    end
  end

  assign tx.tx_ready  = (state == ST_IDLE);
  assign tx.tx_done   = done;
  assign tx.tx_err    = err;
  assign tx.tx_ack_ok = ack_ok_q;
  assign rx_inhibit   = (state != ST_IDLE);
  assign ps2_clk_oe   = clk_oe;
  assign ps2_data_oe  = data_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH  = 50;
  localparam int TMO  = 1500;
  localparam int SYNC = 3;
  localparam int HALF = 20;

  logic clk_50m = 1'b0;
  logic clr_n   = 1'b0;
  logic rx_inhibit, ps2_clk_oe, ps2_data_oe, ps2_clk_in, ps2_data_in;
  logic bfm_clk  = 1'b1;
  logic bfm_data = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ps2_host_tx_if tx_if();

  assign ps2_clk_in  = bfm_clk & ~ps2_clk_oe;
  assign ps2_data_in = bfm_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
    .clk_50m    (clk_50m),
    .clr_n      (clr_n),
    .tx         (tx_if),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #10 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame as the device sees it: start, LSB-first data, odd parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction

  // Completion events, stamped for the transaction checks.
  int         ev_n = 0;
  int         ev_cyc;
  logic       ev_done, ev_err, ev_ack;
  logic [1:0] ev_oe;
  always @(negedge clk_50m) begin
    if (tx_if.tx_done || tx_if.tx_err) begin
      ev_n    <= ev_n + 1;
      ev_cyc  <= cyc;
      ev_done <= tx_if.tx_done;
      ev_err  <= tx_if.tx_err;
      ev_ack  <= tx_if.tx_ack_ok;
      ev_oe   <= {ps2_clk_oe, ps2_data_oe};
    end
  end

  // Cycle model: busy from accept until the done/err cycle, inhibit window timed from accept.
  bit m_busy = 1'b0;
  int m_since = 0;
  bit m_end;
  initial begin
    forever begin
      @(negedge clk_50m);
      m_end = 1'b0;
      if (clr_n) begin
        chk("cyc_ready", tx_if.tx_ready, !m_busy);
        chk("cyc_rx_inhibit", rx_inhibit, m_busy);
        if (!m_busy) begin
          chk("cyc_idle_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
          chk("cyc_idle_pulses", {tx_if.tx_done, tx_if.tx_err}, 2'b00);
        end else begin
          chk("cyc_clk_oe", ps2_clk_oe, m_since <= INH);
          if (m_since < INH)       chk("cyc_inhibit_data_oe", ps2_data_oe, 1'b0);
          else if (m_since <= INH + 1) chk("cyc_start_data_oe", ps2_data_oe, 1'b1);
          chk("cyc_done_err_excl", tx_if.tx_done & tx_if.tx_err, 1'b0);
          m_end = tx_if.tx_done | tx_if.tx_err;
        end
      end
      @(posedge clk_50m);
      if (!clr_n)          m_busy = 1'b0;
      else if (m_busy) begin
        if (m_end) m_busy = 1'b0;
        else       m_since++;
      end else if (tx_if.tx_valid) begin
        m_busy  = 1'b1;
        m_since = 1;
      end
    end
  end

  task automatic bfm(input int nclk, input bit ack, output logic [10:0] frame,
                     output bit got_req, output int t_req);
    frame   = '0;
    got_req = 1'b0;
    t_req   = 0;
    for (int i = 0; i < INH + 40 && !got_req; i++) begin
      @(negedge clk_50m);
      if (ps2_clk_in && !ps2_data_in) begin
        got_req  = 1'b1;
        t_req    = cyc;
        frame[0] = ps2_data_in;
      end
    end
    if (!got_req || nclk == 0) return;
    repeat (10) @(negedge clk_50m);
    for (int i = 1; i <= 10 && i <= nclk; i++) begin
      bfm_clk = 1'b0;
      repeat (HALF) @(negedge clk_50m);
      frame[i] = ps2_data_in;
      bfm_clk = 1'b1;
      repeat (HALF) @(negedge clk_50m);
    end
    if (nclk > 10) begin
      if (ack) bfm_data = 1'b0;
      repeat (3) @(negedge clk_50m);
      bfm_clk = 1'b0;
      repeat (HALF) @(negedge clk_50m);
      bfm_clk = 1'b1;
      repeat (3) @(negedge clk_50m);
      bfm_data = 1'b1;
    end
  endtask

  // mode 0: device ACKs, 1: device NACKs, 2: device never clocks
  task automatic do_xfer(input logic [7:0] d, input int mode, input bit hold);
    logic [10:0] frame;
    bit          got_req, fin;
    int          t_req, n0;
    @(negedge clk_50m);
    chk("xfer_pre_ready", tx_if.tx_ready, 1'b1);
    n0 = ev_n;
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    @(negedge clk_50m);
    if (!hold) begin
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = 8'($urandom);
    end
    fin = 1'b0;
    fork
      begin
        bfm(mode == 2 ? 0 : 11, mode == 0, frame, got_req, t_req);
        fin = 1'b1;
      end
      begin
        while (hold && !fin) begin
          @(negedge clk_50m);
          tx_if.tx_data = 8'($urandom);
        end
      end
    join
    tx_if.tx_valid = 1'b0;
    for (int i = 0; i < TMO + 100 && ev_n == n0; i++) @(negedge clk_50m);
    chk("xfer_req_seen", got_req, 1'b1);
    chk("xfer_end_seen", ev_n != n0, 1'b1);
    chk("xfer_end_oe", ev_oe, 2'b00);
    if (mode == 2) begin
      chk("timeout_err", ev_err, 1'b1);
      chk("timeout_no_done", ev_done, 1'b0);
      chk("timeout_latency", ev_cyc - t_req, TMO - 1);
      chk("timeout_ack_ok", ev_ack, 1'b0);
    end else begin
      chk("xfer_frame", frame, exp_frame(d));
      chk("xfer_done", ev_done, 1'b1);
      chk("xfer_no_err", ev_err, 1'b0);
      chk("xfer_ack_ok", ev_ack, mode == 0);
    end
    repeat (5) @(negedge clk_50m);
    chk("xfer_ack_ok_held", tx_if.tx_ack_ok, mode == 0);
    chk("xfer_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
  endtask

  initial begin
    repeat (60000) @(posedge clk_50m);
    $display("FAIL watchdog: cycle %0d reached, expected bench to finish earlier", cyc);
    $fatal(1);
  end

  initial begin
    logic [10:0] f, ef;
    bit          got;
    int          tq;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(negedge clk_50m);
    chk("reset_ready", tx_if.tx_ready, 1'b1);
    chk("reset_pulses", {tx_if.tx_done, tx_if.tx_err, tx_if.tx_ack_ok}, 3'b000);
    chk("reset_rx_inhibit", rx_inhibit, 1'b0);
    chk("reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    #3 clr_n = 1'b1;

    f = exp_frame(CMD_SET_LEDS); chk("model_frame_ED", f, 11'h7DA);
    f = exp_frame(8'h02);        chk("model_frame_02", f, 11'h404);
    f = exp_frame(CMD_RESET);    chk("model_frame_FF", f, 11'h7FE);
    f = exp_frame(CMD_ENABLE);   chk("model_frame_F4", f, 11'h5E8);

    do_xfer(CMD_SET_LEDS, 0, 1'b0);
    do_xfer(8'h02, 0, 1'b0);
    do_xfer(CMD_RESET, 0, 1'b0);
    do_xfer(8'h3C, 1, 1'b0);
    do_xfer(8'h81, 2, 1'b0);

    // Abort mid-frame with the start of data bit 3 on the wire.
    @(negedge clk_50m);
    tx_if.tx_data  = 8'hA5;
    tx_if.tx_valid = 1'b1;
    @(negedge clk_50m);
    tx_if.tx_valid = 1'b0;
    bfm(4, 1'b0, f, got, tq);
    ef = exp_frame(8'hA5);
    chk("rst_req_seen", got, 1'b1);
    chk("rst_partial_frame", f[4:0], ef[4:0]);
    #3;
    chk("rst_pre_data_oe", ps2_data_oe, 1'b1);
    clr_n = 1'b0;
    #1;
    chk("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("rst_async_ready", tx_if.tx_ready, 1'b1);
    chk("rst_async_flags", {rx_inhibit, tx_if.tx_done, tx_if.tx_err, tx_if.tx_ack_ok}, 4'b0000);
    repeat (3) @(negedge clk_50m);
    #3 clr_n = 1'b1;
    do_xfer(CMD_ENABLE, 0, 1'b0);

    do_xfer(CMD_SET_LEDS, 0, 1'b1);

    for (int k = 0; k < 4; k++) do_xfer(8'($urandom), int'($urandom_range(0, 1)), 1'b0);

    repeat (5) @(negedge clk_50m);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
